// File: rtl/gf180mcu_fd_sc_mcu9t5v0__icgen_pkg.sv
// Shared types and defaults for the icgen clock-gate enable controller.
package gf180mcu_fd_sc_mcu9t5v0__icgen_pkg;

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StDrain = 2'd1,
      StOff   = 2'd2,
      StWake  = 2'd3
   } icgen_state_e;

   localparam int unsigned WakeCycDefault = 2;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__icgen_cnt.sv
// Clearable incrementing counter shared by the DRAIN and WAKE phases.
module gf180mcu_fd_sc_mcu9t5v0__icgen_cnt #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__icgen_ctl.sv
// Enable controller for a negative-edge ICG: idle-count gating plus REQ/ACK wake.
// Define ICGEN_CTL_SCAN_EN to add the SE port (drives TE and freezes the FSM).
module gf180mcu_fd_sc_mcu9t5v0__icgen_ctl
   import gf180mcu_fd_sc_mcu9t5v0__icgen_pkg::*;
#(
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned WAKE_CYC = WakeCycDefault
) (
   input  logic             CLK,
   input  logic             RST,
   inout  wire              VDD,
   inout  wire              VSS,
   input  logic             REQ,
   input  logic             BUSY,
   input  logic             FORCE,
   input  logic [CNT_W-1:0] IDLE_CYC,
`ifdef ICGEN_CTL_SCAN_EN
   input  logic             SE,
`endif
   output logic             E,
   output logic             TE,
   output logic             ACK,
   output logic             GATED
);

   localparam logic [CNT_W-1:0] WakeLast = CNT_W'(WAKE_CYC - 1);

   icgen_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W:0]   cnt_inc;
   logic             cnt_clr, cnt_en;
   logic             idle, frozen;
   logic             e_q, gated_q, ack_q;
   logic             unused_supply;

   assign unused_supply = VDD ^ VSS;

`ifdef ICGEN_CTL_SCAN_EN
   assign frozen = SE;
   assign TE     = SE;
`else
   assign frozen = 1'b0;
   assign TE     = 1'b0;
`endif

   assign idle    = ~REQ & ~BUSY & ~FORCE;
   // One extra bit so the drain compare cannot wrap when IDLE_CYC is lowered.
   assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);

   gf180mcu_fd_sc_mcu9t5v0__icgen_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .CLK (CLK),
      .RST (RST),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (cnt)
   );

   always_comb begin
      state_d = state_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      unique case (state_q)
         StRun: begin
            if (idle && (IDLE_CYC != '0)) begin
               if (IDLE_CYC == CNT_W'(1)) begin
                  state_d = StOff;
               end else begin
                  state_d = StDrain;
                  cnt_en  = 1'b1;
               end
            end
         end
         StDrain: begin
            if (!idle || (IDLE_CYC == '0)) begin
               state_d = StRun;
               cnt_clr = 1'b1;
            end else if (cnt_inc >= {1'b0, IDLE_CYC}) begin
               state_d = StOff;
               cnt_clr = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         StOff: begin
            if (!idle) begin
               state_d = StWake;
               cnt_clr = 1'b1;
            end
         end
         StWake: begin
            // Wake always runs to completion; idle samples are ignored here.
            if (cnt == WakeLast) begin
               state_d = StRun;
               cnt_clr = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: begin
            state_d = StRun;
            cnt_clr = 1'b1;
         end
      endcase
      if (frozen) begin
         state_d = state_q;
         cnt_clr = 1'b0;
         cnt_en  = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StRun;
         e_q     <= 1'b1;
         gated_q <= 1'b0;
         ack_q   <= 1'b0;
      end else if (!frozen) begin
         state_q <= state_d;
         e_q     <= (state_d != StOff);
         gated_q <= (state_d == StOff);
         ack_q   <= REQ && (state_d == StRun);
      end
   end

   assign E     = e_q;
   assign GATED = gated_q;
   assign ACK   = ack_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__icgen_ctl.sv
// Self-checking bench for the icgen enable controller: idle-count model plus directed checks.
module tb_gf180mcu_fd_sc_mcu9t5v0__icgen_ctl;

   localparam int unsigned CntW = 8;
   localparam int unsigned Wake = 2;

   logic            clk = 1'b0;
   logic            rst, req, busy, frc;
   logic [CntW-1:0] idle_cyc;
`ifdef ICGEN_CTL_SCAN_EN
   logic            se;
`endif
   wire             vdd, vss;
   logic            e, te, ack, gated;

   int n_cmp  = 0;
   int n_fail = 0;
   bit started = 1'b0;

   // Model: off flag, edges left in the wake delay, consecutive idle samples seen.
   bit m_off       = 1'b0;
   int m_wake_left = 0;
   int m_idle      = 0;
   bit m_ack       = 1'b0;

   assign vdd = 1'b1;
   assign vss = 1'b0;

   always #5 clk = ~clk;

   gf180mcu_fd_sc_mcu9t5v0__icgen_ctl #(
      .CNT_W    (CntW),
      .WAKE_CYC (Wake)
   ) dut (
      .CLK      (clk),
      .RST      (rst),
      .VDD      (vdd),
      .VSS      (vss),
      .REQ      (req),
      .BUSY     (busy),
      .FORCE    (frc),
      .IDLE_CYC (idle_cyc),
`ifdef ICGEN_CTL_SCAN_EN
      .SE       (se),
`endif
      .E        (e),
      .TE       (te),
      .ACK      (ack),
      .GATED    (gated)
   );

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit quiet;
      bit frz;
      quiet = !req && !busy && !frc;
      frz   = 1'b0;
`ifdef ICGEN_CTL_SCAN_EN
      frz = (se === 1'b1);
`endif
      if (rst) begin
         m_off       = 1'b0;
         m_wake_left = 0;
         m_idle      = 0;
         m_ack       = 1'b0;
      end else if (!frz) begin
         if (m_off) begin
            if (!quiet) begin
               m_off       = 1'b0;
               m_wake_left = Wake;
            end
         end else if (m_wake_left > 0) begin
            m_wake_left--;
         end else if (quiet && (idle_cyc != 0)) begin
            m_idle++;
            if (m_idle >= int'(idle_cyc)) begin
               m_off  = 1'b1;
               m_idle = 0;
            end
         end else begin
            m_idle = 0;
         end
         m_ack = req && !m_off && (m_wake_left == 0);
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   always @(negedge clk) begin
      if (started) begin
         chk("model_E", e, !m_off);
         chk("model_GATED", gated, m_off);
         chk("model_ACK", ack, m_ack);
`ifdef ICGEN_CTL_SCAN_EN
         chk("model_TE", te, se);
`else
         chk("model_TE", te, 1'b0);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; busy = 1'b0; frc = 1'b0; idle_cyc = 8'd4;
`ifdef ICGEN_CTL_SCAN_EN
      se = 1'b0;
`endif
      step();
      started = 1'b1;
      chk("rst_E", e, 1'b1);
      chk("rst_GATED", gated, 1'b0);
      chk("rst_ACK", ack, 1'b0);
      chk("rst_TE", te, 1'b0);
      step();
      rst = 1'b0;

      // Idle with IDLE_CYC=4: E falls on the 4th idle edge.
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k < 4) begin
            chk("drain_E", e, 1'b1);
         end else begin
            chk("gate_E", e, 1'b0);
            chk("gate_GATED", gated, 1'b1);
         end
      end

      // Wake handshake from OFF.
      req = 1'b1;
      step(); chk("wake_E1", e, 1'b1); chk("wake_ACK1", ack, 1'b0);
      step(); chk("wake_ACK2", ack, 1'b0);
      step(); chk("wake_ACK3", ack, 1'b1);
      req = 1'b0;
      step(); chk("ack_drop", ack, 1'b0);

      // BUSY pulse on the 3rd idle cycle restarts the count of 5.
      busy = 1'b1; step(); busy = 1'b0; idle_cyc = 8'd5;
      step(); step();
      busy = 1'b1; step(); busy = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk((k < 5) ? "busy_restart_E" : "busy_gate_E", e, (k < 5) ? 1'b1 : 1'b0);
      end

      // IDLE_CYC=0 never gates; then IDLE_CYC=1 gates on the next edge.
      busy = 1'b1; idle_cyc = 8'd0; step(); busy = 1'b0;
      repeat (100) step();
      chk("nogate_E", e, 1'b1);
      chk("nogate_GATED", gated, 1'b0);
      idle_cyc = 8'd1; step();
      chk("one_E", e, 1'b0);

      // FORCE in the cycle of the gating decision wins.
      frc = 1'b1; idle_cyc = 8'd2; repeat (3) step();
      frc = 1'b0; step();
      frc = 1'b1; step();
      chk("force_wins_E", e, 1'b1);
      frc = 1'b0;

      // Lowering IDLE_CYC mid-drain gates at the next idle sample.
      idle_cyc = 8'd8; repeat (3) step();
      chk("live_hold_E", e, 1'b1);
      idle_cyc = 8'd2; step();
      chk("live_lower_E", e, 0);

      // Asynchronous reset in WAKE with cnt=1.
      req = 1'b1; step(); step();
      #2 rst = 1'b1;
      #1;
      chk("rst_wake_E", e, 1'b1);
      chk("rst_wake_ACK", ack, 1'b0);
      chk("rst_wake_GATED", gated, 1'b0);
      step(); rst = 1'b0; req = 1'b0;
      step(); step();
      chk("regate_GATED", gated, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("rst_off_E", e, 1'b1);
      chk("rst_off_GATED", gated, 1'b0);
      step(); rst = 1'b0;

`ifdef ICGEN_CTL_SCAN_EN
      // Scan freeze in DRAIN, then resume from the held count.
      busy = 1'b1; idle_cyc = 8'd4; repeat (3) step(); busy = 1'b0;
      step(); step();
      se = 1'b1; #1;
      chk("scan_TE", te, 1'b1);
      repeat (20) step();
      chk("scan_hold_E", e, 1'b1);
      se = 1'b0;
      step(); chk("scan_resume_E", e, 1'b1);
      step(); chk("scan_gate_E", e, 1'b0);
`endif

      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
